// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its environment.
// The master side drives the PLL lock flag and restart requests; the slave side is the sequencer.
interface pll_lock_sequencer_if;
    logic       pll_locked;
    logic       restart_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [2:0] seq_state;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;

    modport master (
        output pll_locked, restart_req,
        input  pll_rst, sys_rst_n, ready, fault, seq_state, retry_count, lock_loss_count
    );

    modport slave (
        input  pll_locked, restart_req,
        output pll_rst, sys_rst_n, ready, fault, seq_state, retry_count, lock_loss_count
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on the reference clock: pulses pll_rst, qualifies lock, releases sys_rst_n.
// Optional build macro PLL_SEQ_LOSS_FILTER_EN deglitches lock loss while in RUN.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2,
    parameter int LOSS_FILTER_CYCLES  = 4
) (
    input logic                 refclk,
    input logic                 rst_n,
    pll_lock_sequencer_if.slave bus
);
    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CD  = (LOCK_STABLE_CYCLES > LOSS_FILTER_CYCLES) ? LOCK_STABLE_CYCLES : LOSS_FILTER_CYCLES;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // Counters are loaded with N-1 so each phase lasts exactly N cycles.
    localparam cnt_t RST_LOAD     = cnt_t'(PLL_RST_CYCLES - 1);
    localparam cnt_t TIMEOUT_LOAD = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
    localparam cnt_t STABLE_LOAD  = cnt_t'(LOCK_STABLE_CYCLES - 1);
    localparam cnt_t FILTER_LOAD  = cnt_t'(LOSS_FILTER_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t                 state;
    cnt_t                   cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   pll_rst_q;
    logic                   sys_rst_n_q;
    logic                   ready_q;
    logic                   fault_q;
    logic [1:0]             retry_q;
    logic [7:0]             loss_q;
`ifdef PLL_SEQ_LOSS_FILTER_EN
    logic                   loss_pending;
`endif

    // NOTE: the synchronizer is a pure flop chain; no logic may sit between stages.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // NOTE: every output is a flop written only here, so sys_rst_n cannot glitch on decode.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RESET_PLL;
            cnt         <= RST_LOAD;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= '0;
            loss_q      <= '0;
`ifdef PLL_SEQ_LOSS_FILTER_EN
            loss_pending <= 1'b0;
`endif
        end else if (bus.restart_req) begin
            state       <= S_RESET_PLL;
            cnt         <= RST_LOAD;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            retry_q     <= '0;
`ifdef PLL_SEQ_LOSS_FILTER_EN
            loss_pending <= 1'b0;
`endif
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (cnt == '0) begin
                        state     <= S_WAIT_LOCK;
                        cnt       <= TIMEOUT_LOAD;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= S_STABILIZE;
                        cnt   <= STABLE_LOAD;
                    end else if (cnt == '0) begin
                        if (retry_q != 2'b11) retry_q <= retry_q + 2'd1;
                        pll_rst_q <= 1'b1;
                        if (int'(retry_q) == MAX_RETRIES) begin
                            state   <= S_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state <= S_RESET_PLL;
                            cnt   <= RST_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_STABILIZE: begin
                    // A dropout restarts the wait but is not a failed attempt.
                    if (!locked_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= TIMEOUT_LOAD;
                    end else if (cnt == '0) begin
                        state       <= S_RUN;
                        cnt         <= FILTER_LOAD;
                        sys_rst_n_q <= 1'b1;
                        ready_q     <= 1'b1;
                        retry_q     <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RUN: begin
`ifdef PLL_SEQ_LOSS_FILTER_EN
                    // The filter decision is registered, adding one cycle before the loss acts.
                    if (loss_pending) begin
                        state        <= S_RESET_PLL;
                        cnt          <= RST_LOAD;
                        pll_rst_q    <= 1'b1;
                        sys_rst_n_q  <= 1'b0;
                        ready_q      <= 1'b0;
                        loss_pending <= 1'b0;
                        if (loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
                    end else if (locked_s) begin
                        cnt <= FILTER_LOAD;
                    end else if (cnt == '0) begin
                        loss_pending <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
`else
                    if (!locked_s) begin
                        state       <= S_RESET_PLL;
                        cnt         <= RST_LOAD;
                        pll_rst_q   <= 1'b1;
                        sys_rst_n_q <= 1'b0;
                        ready_q     <= 1'b0;
                        if (loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
                    end
`endif
                end
                S_FAULT: begin
                    pll_rst_q   <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    fault_q     <= 1'b1;
                end
                default: begin
                    state       <= S_RESET_PLL;
                    cnt         <= RST_LOAD;
                    pll_rst_q   <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    ready_q     <= 1'b0;
                    fault_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst         = pll_rst_q;
    assign bus.sys_rst_n       = sys_rst_n_q;
    assign bus.ready           = ready_q;
    assign bus.fault           = fault_q;
    assign bus.seq_state       = state;
    assign bus.retry_count     = retry_q;
    assign bus.lock_loss_count = loss_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus queues timed output snapshots, a monitor
// compares every output change against the queue head.
module tb_pll_lock_sequencer;
    typedef struct packed {
        logic [2:0] st;
        logic       pll;
        logic       sys;
        logic       rdy;
        logic       flt;
        logic [1:0] rc;
        logic [7:0] llc;
    } snap_t;

    typedef struct packed {
        int    cyc;
        snap_t s;
    } exp_t;

    logic  refclk = 1'b0;
    logic  rst_n  = 1'b1;
    int    cyc    = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    exp_t  exp_q[$];
    snap_t prev;

    pll_lock_sequencer_if sif();

    pll_lock_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (3),
        .SYNC_STAGES        (2),
        .LOSS_FILTER_CYCLES (4)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic snap_t cur_snap();
        return {sif.seq_state, sif.pll_rst, sif.sys_rst_n, sif.ready, sif.fault,
                sif.retry_count, sif.lock_loss_count};
    endfunction

    function automatic void ev(input int c, input int st, input bit pll, input bit sys,
                               input bit rdy, input bit flt, input int rc, input int llc);
        exp_t e;
        e.cyc   = c;
        e.s.st  = 3'(st);
        e.s.pll = pll;
        e.s.sys = sys;
        e.s.rdy = rdy;
        e.s.flt = flt;
        e.s.rc  = 2'(rc);
        e.s.llc = 8'(llc);
        exp_q.push_back(e);
    endfunction

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_seq_state"}, 32'(sif.seq_state), 0);
        check({tag, "_pll_rst"}, 32'(sif.pll_rst), 1);
        check({tag, "_sys_rst_n"}, 32'(sif.sys_rst_n), 0);
        check({tag, "_ready"}, 32'(sif.ready), 0);
        check({tag, "_fault"}, 32'(sif.fault), 0);
        check({tag, "_retry_count"}, 32'(sif.retry_count), 0);
        check({tag, "_lock_loss_count"}, 32'(sif.lock_loss_count), 0);
    endtask

    // Monitor: any change of the output snapshot is an event to be matched against the queue.
    always @(negedge refclk) begin
        snap_t cur;
        exp_t  e;
        cur = cur_snap();
        if (rst_n && cur !== prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_event: cycle %0d outputs %h, nothing expected", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("event_outputs", 32'(cur), 32'(e.s));
            end
        end
        prev = cur;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        sif.pll_locked  = 1'b0;
        sif.restart_req = 1'b0;
        #2 rst_n = 1'b0;
        go_to(3);
        check_reset_values("reset");

        // Power-up: lock at cycle 10 after release, sys_rst_n rises 11 cycles later.
        ev(8,  1, 0, 0, 0, 0, 0, 0);
        ev(17, 2, 0, 0, 0, 0, 0, 0);
        ev(25, 3, 0, 1, 1, 0, 0, 0);
        go_to(4);
        rst_n = 1'b1;
        go_to(14);
        sif.pll_locked = 1'b1;

`ifdef PLL_SEQ_LOSS_FILTER_EN
        // 3-cycle drop is ignored; 4-cycle drop acts 7 cycles after the fall.
        ev(47, 0, 1, 0, 0, 0, 0, 1);
        ev(51, 1, 0, 0, 0, 0, 0, 1);
        ev(52, 2, 0, 0, 0, 0, 0, 1);
        ev(60, 3, 0, 1, 1, 0, 0, 1);
        go_to(30); sif.pll_locked = 1'b0;
        go_to(33); sif.pll_locked = 1'b1;
        go_to(40); sif.pll_locked = 1'b0;
        go_to(44); sif.pll_locked = 1'b1;
`else
        // Single-cycle drop in RUN: loss after 3 cycles, then a fresh 4-cycle pll_rst pulse.
        ev(33, 0, 1, 0, 0, 0, 0, 1);
        ev(37, 1, 0, 0, 0, 0, 0, 1);
        ev(38, 2, 0, 0, 0, 0, 0, 1);
        ev(46, 3, 0, 1, 1, 0, 0, 1);
        go_to(30); sif.pll_locked = 1'b0;
        go_to(31); sif.pll_locked = 1'b1;
`endif

        // Restart, one timeout (retry 1), dropout in STABILIZE keeps retry and needs a full dwell.
        ev(71,  0, 1, 0, 0, 0, 0, 1);
        ev(75,  1, 0, 0, 0, 0, 0, 1);
        ev(95,  0, 1, 0, 0, 0, 1, 1);
        ev(99,  1, 0, 0, 0, 0, 1, 1);
        ev(103, 2, 0, 0, 0, 0, 1, 1);
        ev(110, 1, 0, 0, 0, 0, 1, 1);
        ev(115, 2, 0, 0, 0, 0, 1, 1);
        ev(123, 3, 0, 1, 1, 0, 0, 1);
        go_to(70);  sif.restart_req = 1'b1; sif.pll_locked = 1'b0;
        go_to(71);  sif.restart_req = 1'b0;
        go_to(100); sif.pll_locked = 1'b1;
        go_to(107); sif.pll_locked = 1'b0;
        go_to(112); sif.pll_locked = 1'b1;

        // No lock at all: four timed-out attempts then FAULT; restart clears it.
        ev(131, 0, 1, 0, 0, 0, 0, 1);
        ev(135, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            ev(155 + 24 * i, 0, 1, 0, 0, 0, i + 1, 1);
            ev(159 + 24 * i, 1, 0, 0, 0, 0, i + 1, 1);
        end
        ev(227, 4, 1, 0, 0, 1, 3, 1);
        ev(241, 0, 1, 0, 0, 0, 0, 1);
        ev(245, 1, 0, 0, 0, 0, 0, 1);
        go_to(130); sif.restart_req = 1'b1; sif.pll_locked = 1'b0;
        go_to(131); sif.restart_req = 1'b0;
        go_to(240); sif.restart_req = 1'b1;
        go_to(241); sif.restart_req = 1'b0;

        // Async reset during STABILIZE returns every output to reset values at once.
        ev(253, 2, 0, 0, 0, 0, 0, 1);
        go_to(250); sif.pll_locked = 1'b1;
        go_to(256);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        ev(262, 1, 0, 0, 0, 0, 0, 0);
        ev(263, 2, 0, 0, 0, 0, 0, 0);
        ev(271, 3, 0, 1, 1, 0, 0, 0);
        go_to(258);
        rst_n = 1'b1;

        go_to(290);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
